// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg -- shared definitions for the front-panel debug console.
//   SEG_TABLE   : hex digit -> active-low 7-segment code (bit7 = dp, off)
//   SEG_BLANK   : all segments and dp off
//   deb_state_e : states of the single-step key debouncer
//   hex2seg()   : table lookup helper
// -----------------------------------------------------------------------------
package dbg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    REL       = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } deb_state_e;

  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/dbg_console_if.sv
// -----------------------------------------------------------------------------
// dbg_console_if -- panel-side signal bundle of the debug console.
//   key_in     : raw single-step push-button (async, active-high)
//   sel        : probe channel select
//   probe      : NUM_CH channels of 4*DIGITS bits, channel c at [c*4*DIGITS +: 4*DIGITS]
//   auto_run   : free-running step enable (only when DBG_AUTORUN_EN is defined)
//   step_pulse : one-cycle CPU step pulse
//   AN         : active-low one-hot digit enables
//   dispcode   : active-low segments, bit7 = dp
//   deb_state  : debouncer state, exported for observation
// Modports: master = panel/bench side, slave = dbg_console.
// -----------------------------------------------------------------------------
interface dbg_console_if #(
  parameter int NUM_CH = 4,
  parameter int DIGITS = 4,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  import dbg_pkg::*;

  logic                       key_in;
  logic [SEL_W-1:0]           sel;
  logic [NUM_CH*4*DIGITS-1:0] probe;
`ifdef DBG_AUTORUN_EN
  logic                       auto_run;
`endif
  logic                       step_pulse;
  logic [DIGITS-1:0]          AN;
  logic [7:0]                 dispcode;
  deb_state_e                 deb_state;

`ifdef DBG_AUTORUN_EN
  modport master (output key_in, sel, probe, auto_run,
                  input  step_pulse, AN, dispcode, deb_state);
  modport slave  (input  key_in, sel, probe, auto_run,
                  output step_pulse, AN, dispcode, deb_state);
`else
  modport master (output key_in, sel, probe,
                  input  step_pulse, AN, dispcode, deb_state);
  modport slave  (input  key_in, sel, probe,
                  output step_pulse, AN, dispcode, deb_state);
`endif

endinterface

// File: rtl/dbg_debounce.sv
// -----------------------------------------------------------------------------
// dbg_debounce -- 2-flop synchroniser plus 4-state debounce FSM for the
// single-step key. A press must stay stable DEBOUNCE_CYC cycles to be
// accepted (one step_pulse), and a release must stay stable as long before
// the next press can be accepted.
//   clk, rst   : clock, asynchronous active-high reset
//   key_in     : raw key
//   step_pulse : registered one-cycle pulse on accepted press
//   state      : current FSM state (observation)
// -----------------------------------------------------------------------------
module dbg_debounce
  import dbg_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       step_pulse,
  output deb_state_e state
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, key_s_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      key_s_q <= 1'b0;
      state_q <= REL;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= key_in;
      key_s_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // The counter holds the number of consecutive cycles key_s has disagreed
  // with the accepted level; the move happens on the cycle it would reach
  // DEBOUNCE_CYC, so the comparison is against DEBOUNCE_CYC-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      REL: begin
        if (key_s_q) begin
          state_d = PRESS_CHK;
          cnt_d   = CW'(1);
        end
      end
      PRESS_CHK: begin
        if (!key_s_q) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!key_s_q) begin
          state_d = REL_CHK;
          cnt_d   = CW'(1);
        end
      end
      REL_CHK: begin
        if (key_s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
          state_d = REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

  assign step_pulse = pulse_q;
  assign state      = state_q;

endmodule

// File: rtl/dbg_console.sv
// -----------------------------------------------------------------------------
// dbg_console -- front-panel debug console: debounced single-step key and a
// time-multiplexed common-anode hex display of one selected probe channel.
//   CLK, Reset : clock, asynchronous active-high reset
//   bus        : dbg_console_if.slave (key_in, sel, probe, step_pulse, AN,
//                dispcode, deb_state, and auto_run when enabled)
// Optional feature macro: DBG_AUTORUN_EN adds AUTO_PERIOD and auto_run, a
// periodic step generator merged into step_pulse, and dp on digit 0 while
// auto_run is high.
// -----------------------------------------------------------------------------
module dbg_console
  import dbg_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 100000,
`ifdef DBG_AUTORUN_EN
  parameter int AUTO_PERIOD  = 25000000,
`endif
  parameter int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic          CLK,
  input logic          Reset,
  dbg_console_if.slave bus
);

  localparam int CH_W  = 4 * DIGITS;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        disp_q, disp_d;
  logic [CH_W-1:0]   chan_word;
  logic [3:0]        nib;
  logic              key_pulse;

  dbg_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk        (CLK),
    .rst        (Reset),
    .key_in     (bus.key_in),
    .step_pulse (key_pulse),
    .state      (bus.deb_state)
  );

  // Scan timing. The channel is only re-latched on the last digit -> digit 0
  // wrap so a frame never mixes digits of two channels.
  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    ch_d       = ch_q;
    if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = '0;
        ch_d  = bus.sel;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Display outputs for the current index; registered below so they trail
  // index/counter by one cycle. Probe data is read live every cycle.
  always_comb begin
    chan_word = '0;
    nib       = '0;
    an_d      = ~(DIGITS'(1) << idx_q);
    disp_d    = SEG_BLANK;
    if (int'(ch_q) < NUM_CH) begin
      chan_word = bus.probe[int'(ch_q)*CH_W +: CH_W];
      nib       = chan_word[int'(idx_q)*4 +: 4];
      disp_d    = hex2seg(nib);
    end
`ifdef DBG_AUTORUN_EN
    if (bus.auto_run && idx_q == '0) disp_d[7] = 1'b0;
`endif
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      ch_q       <= '0;
      an_q       <= '1;
      disp_q     <= SEG_BLANK;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      ch_q       <= ch_d;
      an_q       <= an_d;
      disp_q     <= disp_d;
    end
  end

  assign bus.AN       = an_q;
  assign bus.dispcode = disp_q;

`ifdef DBG_AUTORUN_EN
  localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  logic          auto_pulse_q, auto_pulse_d;

  // Counter sits at zero while auto_run is low, so the first pulse lands
  // exactly AUTO_PERIOD cycles after auto_run rises.
  always_comb begin
    auto_cnt_d   = '0;
    auto_pulse_d = 1'b0;
    if (bus.auto_run) begin
      if (auto_cnt_q == AW'(AUTO_PERIOD - 1)) auto_pulse_d = 1'b1;
      else                                    auto_cnt_d   = auto_cnt_q + AW'(1);
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      auto_cnt_q   <= '0;
      auto_pulse_q <= 1'b0;
    end else begin
      auto_cnt_q   <= auto_cnt_d;
      auto_pulse_q <= auto_pulse_d;
    end
  end

  // Both sources are registered pulses on the same cycle grid, so a plain OR
  // merges coincident key and auto steps into one pulse.
  assign bus.step_pulse = key_pulse | auto_pulse_q;
`else
  assign bus.step_pulse = key_pulse;
`endif

endmodule

// File: tb/tb_dbg_console.sv
// -----------------------------------------------------------------------------
// tb_dbg_console -- self-checking bench for dbg_console (NUM_CH=4 and a
// NUM_CH=3 copy, DIGITS=4, SCAN_DIV=4, DEBOUNCE_CYC=8; AUTO_PERIOD=10 when
// DBG_AUTORUN_EN is defined). A cycle-level behavioural model predicts every
// output; directed literal checks pin the model to known values.
// -----------------------------------------------------------------------------
module tb_dbg_console;
  import dbg_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DIGITS   = 4;
  localparam int DEB      = 8;
  localparam int FRAME    = SCAN_DIV * DIGITS;
  localparam int AUTO_P   = 10;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  logic        key_in = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [63:0] probe = 64'h0;
`ifdef DBG_AUTORUN_EN
  logic        auto_run = 1'b0;
`endif

  dbg_console_if #(.NUM_CH(4), .DIGITS(4)) bus4 ();
  dbg_console_if #(.NUM_CH(3), .DIGITS(4)) bus3 ();

  assign bus4.key_in = key_in;
  assign bus4.sel    = sel;
  assign bus4.probe  = probe;
  assign bus3.key_in = key_in;
  assign bus3.sel    = sel;
  assign bus3.probe  = probe[47:0];
`ifdef DBG_AUTORUN_EN
  assign bus4.auto_run = auto_run;
  assign bus3.auto_run = auto_run;
`endif

  dbg_console #(.NUM_CH(4), .DIGITS(4), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEB)
`ifdef DBG_AUTORUN_EN
    , .AUTO_PERIOD(AUTO_P)
`endif
  ) u_dut4 (.CLK(CLK), .Reset(Reset), .bus(bus4));

  dbg_console #(.NUM_CH(3), .DIGITS(4), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEB)
`ifdef DBG_AUTORUN_EN
    , .AUTO_PERIOD(AUTO_P)
`endif
  ) u_dut3 (.CLK(CLK), .Reset(Reset), .bus(bus3));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] seg_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [7:0] disp_for(input int nch, input int ch, input int idx,
                                          input logic [63:0] pr, input bit ar);
    logic [7:0]  v;
    logic [63:0] t;
    if (ch >= nch) v = 8'hFF;
    else begin
      t = pr >> (ch * 16 + idx * 4);
      v = seg_ref[t[3:0]];
    end
    if (ar && idx == 0) v[7] = 1'b0;
    return v;
  endfunction

  bit          key_dly[$];      // key_in as seen after the two synchroniser stages
  bit          m_acc;           // accepted (debounced) key level
  int          m_run;           // consecutive sampled cycles disagreeing with m_acc
  int          m_k;             // cycles since reset release
  int          m_lat;           // channel shown in the current frame
  int          m_auto;          // cycles auto_run has been high since last auto step
  logic [3:0]  exp_an = 4'hF;
  logic [7:0]  exp_d4 = 8'hFF;
  logic [7:0]  exp_d3 = 8'hFF;
  logic        exp_step = 1'b0;

  always @(posedge CLK) begin : model
    bit ks, kfire, afire, ar;
    int idx;
    if (Reset) begin
      key_dly.delete();
      key_dly.push_back(1'b0);
      key_dly.push_back(1'b0);
      m_acc = 1'b0; m_run = 0; m_k = 0; m_lat = 0; m_auto = 0;
      exp_an = 4'hF; exp_d4 = 8'hFF; exp_d3 = 8'hFF; exp_step = 1'b0;
    end else begin
      ks = key_dly.pop_front();
      key_dly.push_back(key_in);
      kfire = 1'b0;
      if (ks != m_acc) begin
        m_run++;
        if (m_run == DEB) begin
          m_acc = ks;
          m_run = 0;
          kfire = ks;
        end
      end else m_run = 0;
      afire = 1'b0;
      ar    = 1'b0;
`ifdef DBG_AUTORUN_EN
      ar = auto_run;
      if (auto_run) begin
        m_auto++;
        if (m_auto == AUTO_P) begin afire = 1'b1; m_auto = 0; end
      end else m_auto = 0;
`endif
      exp_step = kfire | afire;
      idx      = (m_k / SCAN_DIV) % DIGITS;
      exp_an   = ~(4'b0001 << idx);
      exp_d4   = disp_for(4, m_lat, idx, probe, ar);
      exp_d3   = disp_for(3, m_lat, idx, probe, ar);
      m_k++;
      if (m_k % FRAME == 0) m_lat = int'(sel);
    end
  end

  // One compare process: every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (Reset) begin
      chk("rst_an4",   bus4.AN,         4'hF);
      chk("rst_disp4", bus4.dispcode,   8'hFF);
      chk("rst_step4", bus4.step_pulse, 1'b0);
      chk("rst_disp3", bus3.dispcode,   8'hFF);
    end else begin
      chk("an4",   bus4.AN,         exp_an);
      chk("disp4", bus4.dispcode,   exp_d4);
      chk("step4", bus4.step_pulse, exp_step);
      chk("an3",   bus3.AN,         exp_an);
      chk("disp3", bus3.dispcode,   exp_d3);
      chk("step3", bus3.step_pulse, exp_step);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset(input int n);
    @(posedge CLK); #2 Reset = 1'b1;
    repeat (n) @(posedge CLK);
    #2 Reset = 1'b0;
  endtask

  // Observe n cycles; step must be high only at cycle pulse_at (0 = never).
  task automatic step_window(input string name, input int n, input int pulse_at);
    for (int i = 1; i <= n; i++) begin
      cyc();
      chk(name, bus4.step_pulse, (i == pulse_at) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [3:0] an_lit [4];
    logic [7:0] dp_lit [4];
    int hold;
    bit seen;
    an_lit = '{4'hE, 4'hD, 4'hB, 4'h7};
    dp_lit = '{8'h88, 8'hA4, 8'h8E, 8'hF9};
    probe  = {16'h0000, 16'h3456, 16'hC0DE, 16'h1F2A};

    // Reset held 3 cycles.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("lit_rst_an",   bus4.AN,         4'hF);
    chk("lit_rst_disp", bus4.dispcode,   8'hFF);
    chk("lit_rst_step", bus4.step_pulse, 1'b0);
    @(posedge CLK); #2 Reset = 1'b0;

    // Scan of ch0 = 16'h1F2A, two full frames.
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc();
      chk("lit_scan_an",   bus4.AN,       an_lit[(i % FRAME) / SCAN_DIV]);
      chk("lit_scan_disp", bus4.dispcode, dp_lit[(i % FRAME) / SCAN_DIV]);
    end

    // Tear-free select: switch to ch2 while digit 1 is lit.
    for (int w = 0; w < 40 && bus4.AN !== 4'hD; w++) @(negedge CLK);
    chk("lit_wait_d", bus4.AN, 4'hD);
    sel  = 2'd2;
    seen = 1'b0;
    for (int w = 0; w < 24 && !seen; w++) begin
      @(negedge CLK);
      if (bus4.AN === 4'hB) chk("lit_tear_d2", bus4.dispcode, 8'h8E);
      if (bus4.AN === 4'h7) chk("lit_tear_d3", bus4.dispcode, 8'hF9);
      if (bus4.AN === 4'hE) begin
        chk("lit_new_ch_d0", bus4.dispcode, 8'h82);
        seen = 1'b1;
      end
    end
    chk("lit_tear_reached", seen, 1'b1);

    // Debounce: long press -> one pulse at cycle 10.
    repeat (12) cyc();
    key_in = 1'b1;
    step_window("lit_press", 20, 10);
    key_in = 1'b0;
    step_window("lit_release", 12, 0);

    // 5-cycle glitches never qualify.
    for (int g = 0; g < 3; g++) begin
      key_in = 1'b1;
      step_window("lit_glitch", 5, 0);
      key_in = 1'b0;
      step_window("lit_glitch", 5, 0);
    end
    step_window("lit_glitch", 10, 0);

    // Press, release for 8 cycles, press again -> second pulse.
    key_in = 1'b1;
    step_window("lit_press_a", 20, 10);
    key_in = 1'b0;
    repeat (8) cyc();
    key_in = 1'b1;
    step_window("lit_press_b", 20, 10);
    key_in = 1'b0;
    step_window("lit_release_b", 12, 0);

    // Out-of-range channel on the NUM_CH=3 copy.
    sel = 2'd3;
    repeat (2 * FRAME) cyc();
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      chk("lit_blank3", bus3.dispcode, 8'hFF);
    end
    sel = 2'd1;

    // Reset in PRESS_CHK with counter at 6; key stays high through it.
    key_in = 1'b1;
    repeat (8) @(posedge CLK);
    #2 chk("lit_press_state", bus4.deb_state, PRESS_CHK);
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #2 Reset = 1'b0;
    step_window("lit_after_rst", 15, 10);
    key_in = 1'b0;
    step_window("lit_after_rst_rel", 12, 0);

`ifdef DBG_AUTORUN_EN
    // Auto steps at 10, 20, 30; a key press confirming at 20 merges.
    auto_run = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (i == 10) key_in = 1'b1;
      chk("lit_auto", bus4.step_pulse, (i % AUTO_P == 0) ? 1'b1 : 1'b0);
      if (bus4.AN === 4'hE) chk("lit_auto_dp", bus4.dispcode[7], 1'b0);
    end
    auto_run = 1'b0;
    key_in   = 1'b0;
    repeat (12) cyc();
`endif

    // Randomised traffic checked by the model.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        key_in = $urandom_range(0, 1);
        hold   = $urandom_range(1, 14);
      end
      hold--;
      if ($urandom_range(0, 39) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) probe = {$urandom, $urandom};
`ifdef DBG_AUTORUN_EN
      if ($urandom_range(0, 99) == 0) auto_run = ~auto_run;
`endif
      if (i % 1000 == 999) do_reset(2);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
